// File: rtl/pcpi_insn_loader.sv
// PCPI front-end: assembles a 32-bit instruction from strobed nibbles,
// issues it on the PCPI handshake and serves the result back one byte at a time.
module pcpi_insn_loader #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nib_strobe,
  input  logic [3:0]  nib_data,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic        pcpi_wait,
  input  logic [31:0] pcpi_rd,
  input  logic [1:0]  res_sel,
  output logic [7:0]  res_byte,
  output logic [2:0]  nib_count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        res_wr
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          strobe_q;
  logic          arm_q;
  logic [31:0]   insn_q, insn_d;
  logic [31:0]   res_q, res_d;
  logic [7:0]    byte_q;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
  logic          wr_q, wr_d;
  logic          rise;
  logic          tmo;

  // arm_q stays low until the strobe is seen low once after reset,
  // so a strobe already high at reset release loads nothing.
  assign rise = nib_strobe & ~strobe_q & arm_q;
  assign tmo  = ~pcpi_wait & (to_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      strobe_q <= 1'b0;
      arm_q    <= 1'b0;
      insn_q   <= '0;
      res_q    <= '0;
      byte_q   <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= nib_strobe;
      arm_q    <= arm_q | ~nib_strobe;
      insn_q   <= insn_d;
      res_q    <= res_d;
      byte_q   <= res_q[{res_sel, 3'b000} +: 8];
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (rise && cnt_q == 3'd7) state_d = ISSUE;
      ISSUE:   if (pcpi_ready || tmo) state_d = DONE;
      DONE:    if (rise) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    insn_d = insn_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    to_d   = to_q;
    err_d  = err_q;
    wr_d   = wr_q;
    unique case (state_q)
      LOAD: begin
        if (rise) begin
          insn_d[{cnt_q, 2'b00} +: 4] = nib_data;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) to_d = '0;
        end
      end
      ISSUE: begin
        // ready has priority over a coincident timeout
        if (pcpi_ready) begin
          res_d = pcpi_wr ? pcpi_rd : 32'h0;
          wr_d  = pcpi_wr;
          err_d = 1'b0;
        end else if (tmo) begin
          res_d = 32'h0;
          wr_d  = 1'b0;
          err_d = 1'b1;
        end else if (!pcpi_wait) begin
          to_d = to_q + TW'(1);
        end
      end
      DONE: begin
        if (rise) begin
          insn_d[3:0] = nib_data;
          cnt_d = 3'd1;
          err_d = 1'b0;
          wr_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pcpi_valid = (state_q == ISSUE);
    busy       = (state_q == ISSUE);
    done       = (state_q == DONE);
  end

  assign pcpi_insn = insn_q;
  assign res_byte  = byte_q;
  assign nib_count = cnt_q;
  assign err       = err_q;
  assign res_wr    = wr_q;

endmodule

// File: tb/tb_pcpi_insn_loader.sv
// Directed + randomized bench for pcpi_insn_loader against a nibble/
// result model built from the loader's external behaviour.
module tb_pcpi_insn_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nib_strobe;
  logic [3:0]  nib_data;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic        pcpi_wait;
  logic [31:0] pcpi_rd;
  logic [1:0]  res_sel;
  logic [7:0]  res_byte;
  logic [2:0]  nib_count;
  logic        busy;
  logic        done;
  logic        err;
  logic        res_wr;

  pcpi_insn_loader #(.TIMEOUT(16), .TW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nib_strobe (nib_strobe),
    .nib_data   (nib_data),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_wait  (pcpi_wait),
    .pcpi_rd    (pcpi_rd),
    .res_sel    (res_sel),
    .res_byte   (res_byte),
    .nib_count  (nib_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .res_wr     (res_wr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model: instruction image, nibble position, last result
  logic [31:0] m_insn;
  int          m_pos;
  logic [31:0] m_res;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one strobe pulse; checks count and whether valid should now be up
  task automatic nib(input logic [3:0] v, input bit exp_valid);
    nib_data   = v;
    nib_strobe = 1'b1;
    step();
    m_insn[4*m_pos +: 4] = v;
    m_pos = (m_pos + 1) % 8;
    chk("nib_count", 32'(nib_count), 32'(m_pos));
    chk("valid_at_nib", 32'(pcpi_valid), 32'(exp_valid));
    nib_strobe = 1'b0;
    step();
  endtask

  task automatic load_rand();
    for (int i = 0; i < 8; i++) nib(4'($urandom), i == 7);
    chk("insn_loaded", pcpi_insn, m_insn);
    chk("busy_issue", 32'(busy), 32'd1);
  endtask

  task automatic read_bytes();
    for (int s = 0; s < 4; s++) begin
      res_sel = 2'(s);
      step();
      chk("res_byte", 32'(res_byte), 32'(m_res[8*s +: 8]));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_insn"}, pcpi_insn, 32'h0);
    chk({tag, "_cnt"}, 32'(nib_count), 32'h0);
    chk({tag, "_valid"}, 32'(pcpi_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_reswr"}, 32'(res_wr), 32'h0);
    chk({tag, "_byte"}, 32'(res_byte), 32'h0);
  endtask

  initial begin
    logic [3:0]  seq [8];
    logic [31:0] rd;
    int          nowait;
    bit          w;

    rst_n = 1'b0; nib_strobe = 1'b0; nib_data = 4'h0;
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_wait = 1'b0;
    pcpi_rd = 32'h0; res_sel = 2'd0;
    m_insn = 32'h0; m_pos = 0; m_res = 32'h0;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(); step();

    // basic load B,2,0,0,0,0,C,0
    seq = '{4'hB, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'h0};
    for (int i = 0; i < 8; i++) nib(seq[i], i == 7);
    chk("insn_0C00002B", pcpi_insn, 32'h0C00002B);
    chk("insn_model", pcpi_insn, m_insn);
    step(); step();
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEADBEEF;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    m_res = 32'hDEADBEEF;
    chk("rdy_done", 32'(done), 32'd1);
    chk("rdy_reswr", 32'(res_wr), 32'd1);
    chk("rdy_err", 32'(err), 32'd0);
    chk("rdy_valid", 32'(pcpi_valid), 32'd0);
    read_bytes();

    // rise in DONE starts the next instruction at nibble 0
    nib(4'h5, 1'b0);
    chk("done_rise_done", 32'(done), 32'd0);
    chk("done_rise_reswr", 32'(res_wr), 32'd0);
    chk("done_rise_insn", pcpi_insn, m_insn);
    chk("done_rise_nib0", 32'(pcpi_insn[3:0]), 32'h5);
    for (int i = 1; i < 8; i++) nib(4'($urandom), i == 7);
    chk("insn_rand", pcpi_insn, m_insn);

    // pure timeout, strobe activity during ISSUE ignored
    for (int k = 0; k < 14; k++) begin
      nib_strobe = 1'(k % 2);
      nib_data   = 4'($urandom);
      step();
    end
    nib_strobe = 1'b0;
    chk("tmo_early_done", 32'(done), 32'd0);
    chk("issue_insn_hold", pcpi_insn, m_insn);
    chk("issue_cnt_hold", 32'(nib_count), 32'd0);
    step();
    m_res = 32'h0;
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_reswr", 32'(res_wr), 32'd0);
    chk("tmo_valid", 32'(pcpi_valid), 32'd0);
    read_bytes();

    // wait held for 40 cycles, then ready
    load_rand();
    pcpi_wait = 1'b1;
    repeat (40) step();
    chk("wait_no_done", 32'(done), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    rd = $urandom | 32'h1;
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = rd;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_wait = 1'b0;
    m_res = rd;
    chk("wait_done", 32'(done), 32'd1);
    chk("wait_err", 32'(err), 32'd0);
    chk("wait_reswr", 32'(res_wr), 32'd1);
    read_bytes();

    // random wait pattern: timeout after 16 non-wait cycles
    load_rand();
    nowait = 1;
    for (int c = 0; c < 200 && nowait < 16; c++) begin
      w = 1'($urandom_range(0, 1));
      pcpi_wait = w;
      step();
      if (!w) nowait++;
      chk("rwait_done", 32'(done), 32'(nowait >= 16));
    end
    pcpi_wait = 1'b0;
    chk("rwait_err", 32'(err), 32'd1);
    m_res = 32'h0;

    // ready with pcpi_wr=0 after a nonzero result
    load_rand();
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = $urandom | 32'h100;
    m_res = pcpi_rd;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    read_bytes();
    load_rand();
    step();
    pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = $urandom | 32'h1;
    step();
    pcpi_ready = 1'b0;
    m_res = 32'h0;
    chk("nowr_done", 32'(done), 32'd1);
    chk("nowr_reswr", 32'(res_wr), 32'd0);
    chk("nowr_err", 32'(err), 32'd0);
    read_bytes();

    // ready coincident with the 16th non-wait cycle
    load_rand();
    repeat (14) step();
    chk("coinc_pre", 32'(done), 32'd0);
    rd = $urandom;
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = rd;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    m_res = rd;
    chk("coinc_done", 32'(done), 32'd1);
    chk("coinc_err", 32'(err), 32'd0);
    chk("coinc_reswr", 32'(res_wr), 32'd1);
    read_bytes();

    // strobe held high 10 cycles loads one nibble
    nib_data = 4'($urandom);
    m_insn[3:0] = nib_data;
    m_pos = 1;
    nib_strobe = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      nib_data = 4'($urandom);
    end
    chk("held_cnt", 32'(nib_count), 32'd1);
    chk("held_insn", pcpi_insn, m_insn);
    chk("held_done", 32'(done), 32'd0);
    nib_strobe = 1'b0;
    step();

    // reset after 5 nibbles, strobe high across release
    for (int i = 1; i < 5; i++) nib(4'($urandom), 1'b0);
    chk("five_cnt", 32'(nib_count), 32'd5);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_load");
    m_insn = 32'h0; m_pos = 0; m_res = 32'h0;
    nib_strobe = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rel_high_cnt", 32'(nib_count), 32'd0);
    nib_strobe = 1'b0;
    step();
    nib(4'h9, 1'b0);
    chk("rel_first_nib", pcpi_insn, m_insn);
    for (int i = 1; i < 8; i++) nib(4'($urandom), i == 7);
    chk("rel_insn", pcpi_insn, m_insn);

    // reset in ISSUE drops valid at once
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_issue");
    m_insn = 32'h0; m_pos = 0; m_res = 32'h0;
    step();
    rst_n = 1'b1;
    step(); step();
    load_rand();
    rd = $urandom;
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = rd;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    m_res = rd;
    chk("fresh_done", 32'(done), 32'd1);
    chk("fresh_err", 32'(err), 32'd0);
    read_bytes();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
